// File: rtl/dev_bus_pkg.sv
// Shared types and constants for the data-side device bus bridge.
package dev_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned PAGE_W = 16;
  localparam int unsigned CNT_W  = 8;

  localparam logic [PAGE_W-1:0] PAGE_IO   = 16'hBFD0;
  localparam logic [PAGE_W-1:0] PAGE_PER2 = 16'hBFD2;
  localparam logic [PAGE_W-1:0] PAGE_PER3 = 16'hBFD3;

  localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF;

  // Request as latched from the core and broadcast to every device
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   we;
    logic [DATA_W-1:0] data;
  } dev_req_t;

endpackage

// File: rtl/dev_addr_decode.sv
// Page decoder: one-hot device select from the upper address half.
// Lowest matching channel >= 1 wins; channel 0 is the fallback.
module dev_addr_decode
  import dev_bus_pkg::*;
#(
  parameter int unsigned             NUM_DEV  = 4,
  parameter logic [NUM_DEV*16-1:0]   DEV_BASE = {PAGE_PER3, PAGE_PER2, PAGE_IO, 16'h0000}
) (
  input  logic [PAGE_W-1:0]  page,
  output logic [NUM_DEV-1:0] sel_c
);

  always_comb begin
    sel_c    = '0;
    sel_c[0] = 1'b1;
    // Descending scan so the lowest matching index is the last writer
    for (int i = NUM_DEV - 1; i >= 1; i--) begin
      if (page == DEV_BASE[16*i +: 16]) begin
        sel_c    = '0;
        sel_c[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dev_bus_bridge.sv
// Data-port bridge: decodes core accesses onto NUM_DEV devices and holds the
// core until the selected device acks. DEV_BUS_TIMEOUT_EN adds timeout/bus_err.
module dev_bus_bridge
  import dev_bus_pkg::*;
#(
  parameter int unsigned           NUM_DEV  = 4,
  parameter logic [NUM_DEV*16-1:0] DEV_BASE = {PAGE_PER3, PAGE_PER2, PAGE_IO, 16'h0000},
  parameter int unsigned           TIMEOUT  = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dce,
  input  logic [BE_W-1:0]           we,
  input  logic [ADDR_W-1:0]         daddr,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic                      dready,
  output logic                      bus_err,
  output logic [NUM_DEV-1:0]        dev_ce,
  output logic [BE_W-1:0]           dev_we,
  output logic [ADDR_W-1:0]         dev_addr,
  output logic [DATA_W-1:0]         dev_din,
  input  logic [NUM_DEV*DATA_W-1:0] dev_dout,
  input  logic [NUM_DEV-1:0]        dev_ack
);

  // Elaboration-time parameter sanity
  if (NUM_DEV < 2 || NUM_DEV > 8) begin : g_bad_num_dev
    $error("dev_bus_bridge: NUM_DEV out of range");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("dev_bus_bridge: TIMEOUT out of range");
  end

  state_e              state_q, state_d;
  dev_req_t            req_q, req_d;
  logic [NUM_DEV-1:0]  ce_q, ce_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dready_q, dready_d;
  logic [NUM_DEV-1:0]  sel_c;
  logic [DATA_W-1:0]   rdata_c;
  logic                ack_c;

`ifdef DEV_BUS_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                berr_q, berr_d;
`endif

  dev_addr_decode #(
    .NUM_DEV  (NUM_DEV),
    .DEV_BASE (DEV_BASE)
  ) u_decode (
    .page  (daddr[ADDR_W-1 -: PAGE_W]),
    .sel_c (sel_c)
  );

  // Read-data mux and ack qualification, both gated by the live select
  always_comb begin
    rdata_c = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (ce_q[i]) begin
        rdata_c = rdata_c | dev_dout[DATA_W*i +: DATA_W];
      end
    end
  end

  assign ack_c = |(dev_ack & ce_q);

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    ce_d     = ce_q;
    dout_d   = dout_q;
    dready_d = 1'b0;
`ifdef DEV_BUS_TIMEOUT_EN
    cnt_d    = cnt_q;
    berr_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (dce) begin
          state_d    = ST_ACCESS;
          req_d.addr = daddr;
          req_d.we   = we;
          req_d.data = din;
          ce_d       = sel_c;
`ifdef DEV_BUS_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      ST_ACCESS: begin
`ifdef DEV_BUS_TIMEOUT_EN
        cnt_d = CNT_W'(cnt_q + 1'b1);
`endif
        if (ack_c) begin
          state_d  = ST_RESP;
          ce_d     = '0;
          dready_d = 1'b1;
          if (req_q.we == '0) begin
            dout_d = rdata_c;
          end
        end
`ifdef DEV_BUS_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_CNT) begin
          state_d  = ST_RESP;
          ce_d     = '0;
          dready_d = 1'b1;
          berr_d   = 1'b1;
          dout_d   = ERR_DATA;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ce_d    = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      ce_q     <= '0;
      dout_q   <= '0;
      dready_q <= 1'b0;
`ifdef DEV_BUS_TIMEOUT_EN
      cnt_q    <= '0;
      berr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      ce_q     <= ce_d;
      dout_q   <= dout_d;
      dready_q <= dready_d;
`ifdef DEV_BUS_TIMEOUT_EN
      cnt_q    <= cnt_d;
      berr_q   <= berr_d;
`endif
    end
  end

  assign dout     = dout_q;
  assign dready   = dready_q;
  assign dev_ce   = ce_q;
  assign dev_we   = req_q.we;
  assign dev_addr = req_q.addr;
  assign dev_din  = req_q.data;

`ifdef DEV_BUS_TIMEOUT_EN
  assign bus_err = berr_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_dev_bus_bridge.sv
// Scoreboard bench for dev_bus_bridge: directed accesses push expected
// responses; a negedge monitor pops and checks on every dready pulse.
module tb_dev_bus_bridge;

  localparam int unsigned NUM_DEV = 4;
  localparam int unsigned TIMEOUT = 15;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    dce;
  logic [3:0]              we;
  logic [31:0]             daddr;
  logic [31:0]             din;
  logic [31:0]             dout;
  logic                    dready;
  logic                    bus_err;
  logic [NUM_DEV-1:0]      dev_ce;
  logic [3:0]              dev_we;
  logic [31:0]             dev_addr;
  logic [31:0]             dev_din;
  logic [NUM_DEV*32-1:0]   dev_dout;
  logic [NUM_DEV-1:0]      dev_ack;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_dout = 32'h0;

  dev_bus_bridge #(
    .NUM_DEV (NUM_DEV),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dce      (dce),
    .we       (we),
    .daddr    (daddr),
    .din      (din),
    .dout     (dout),
    .dready   (dready),
    .bus_err  (bus_err),
    .dev_ce   (dev_ce),
    .dev_we   (dev_we),
    .dev_addr (dev_addr),
    .dev_din  (dev_din),
    .dev_dout (dev_dout),
    .dev_ack  (dev_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 3000) begin
      $display("FAIL watchdog: cycle %0d exceeded limit 3000", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every dready pulse must match the oldest expected response
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dready === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_dready: got dready=1 expected no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dout", dout, e.data);
        chk("bus_err", 32'(bus_err), 32'(e.err));
        chk("dready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // One access: drive request, play the device side, return in the RESP cycle
  task automatic do_access(input logic [31:0] addr, input logic [3:0] wen,
                           input logic [31:0] wdata, input int dev, input int waits,
                           input logic [31:0] rdata, input int stray, input bit keep);
    exp_t               e;
    int                 a;
    logic [NUM_DEV-1:0] exp_ce;
    exp_ce      = '0;
    exp_ce[dev] = 1'b1;
    @(negedge clk);
    dce   = 1'b1;
    daddr = addr;
    we    = wen;
    din   = wdata;
    a     = cyc + 1;
    e.data = (wen != 4'h0) ? last_dout : rdata;
    e.err  = 1'b0;
    e.cyc  = a + 1 + waits;
    sb.push_back(e);
    last_dout = e.data;
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      if (!keep) dce = 1'b0;
      daddr = ~addr;
      we    = ~wen;
      din   = ~wdata;
      chk("dev_ce", 32'(dev_ce), 32'(exp_ce));
      chk("dev_addr", dev_addr, addr);
      if (k == 0) begin
        chk("dev_we", 32'(dev_we), 32'(wen));
        chk("dev_din", dev_din, wdata);
      end
      dev_ack = '0;
      if (k == waits) begin
        dev_ack[dev]            = 1'b1;
        dev_dout[32*dev +: 32]  = rdata;
      end else if (stray >= 0) begin
        dev_ack[stray]           = 1'b1;
        dev_dout[32*stray +: 32] = 32'hBAD0BAD0;
      end
    end
    @(negedge clk);
    dev_ack = '0;
    chk("dev_ce_resp", 32'(dev_ce), 32'h0);
  endtask

  initial begin
    int a;
    rst_n    = 1'b0;
    dce      = 1'b0;
    we       = 4'h0;
    daddr    = 32'h0;
    din      = 32'h0;
    dev_dout = '0;
    dev_ack  = '0;

    repeat (2) @(negedge clk);
    chk("rst_dev_ce", 32'(dev_ce), 32'h0);
    chk("rst_dout", dout, 32'h0);
    chk("rst_dready", 32'(dready), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("rst_dev_addr", dev_addr, 32'h0);
    chk("rst_dev_din", dev_din, 32'h0);
    chk("rst_dev_we", 32'(dev_we), 32'h0);
    rst_n = 1'b1;

    // RAM read, zero wait
    do_access(32'h0000_0100, 4'h0, 32'h0, 0, 0, 32'h1234_5678, -1, 1'b0);
    // IO write, 3 wait states; dout keeps the last read
    do_access(32'hBFD0_0004, 4'hF, 32'hA5A5_A5A5, 1, 3, 32'h0, -1, 1'b0);
    // Stray ack from channel 3 while channel 1 is selected
    do_access(32'hBFD0_0010, 4'h0, 32'h0, 1, 2, 32'hCAFE_0001, 3, 1'b0);
    // Remaining pages and an unmapped page falling back to RAM
    do_access(32'hBFD2_0008, 4'h0, 32'h0, 2, 1, 32'h2222_0008, -1, 1'b0);
    do_access(32'hBFD3_FFFC, 4'h3, 32'h0000_BEEF, 3, 0, 32'h0, -1, 1'b0);
    do_access(32'hBFD1_0000, 4'h0, 32'h0, 0, 0, 32'h0BFD_1000, -1, 1'b0);

    // Acks while idle must not produce a completion
    @(negedge clk);
    dev_ack = '1;
    repeat (3) @(negedge clk);
    chk("idle_ack_dev_ce", 32'(dev_ce), 32'h0);
    dev_ack = '0;

    // Back-to-back with dce held high: dready in cycles 2, 5, 8
    do_access(32'h0000_0200, 4'h0, 32'h0, 0, 0, 32'h1111_1111, -1, 1'b1);
    do_access(32'hBFD3_0020, 4'h0, 32'h0, 3, 0, 32'h3333_3333, -1, 1'b1);
    do_access(32'h0000_0204, 4'h0, 32'h0, 0, 0, 32'h4444_4444, -1, 1'b0);

    // Ack arriving in the very cycle the timeout would fire: ack wins
    do_access(32'hBFD3_0000, 4'h0, 32'h0, 3, TIMEOUT, 32'h0F0F_1234, -1, 1'b0);

    // Unresponsive device
    @(negedge clk);
    dce   = 1'b1;
    daddr = 32'hBFD2_0000;
    we    = 4'h0;
    a     = cyc + 1;
`ifdef DEV_BUS_TIMEOUT_EN
    sb.push_back('{data: 32'hDEADBEEF, err: 1'b1, cyc: a + TIMEOUT + 1});
    last_dout = 32'hDEADBEEF;
    @(negedge clk);
    dce = 1'b0;
    chk("to_dev_ce", 32'(dev_ce), 32'h4);
    repeat (TIMEOUT + 1) @(negedge clk);
    chk("to_dev_ce_resp", 32'(dev_ce), 32'h0);
`else
    @(negedge clk);
    dce = 1'b0;
    repeat (TIMEOUT + 10) @(negedge clk);
    chk("hang_dev_ce", 32'(dev_ce), 32'h4);
    chk("hang_started", 32'(cyc - a), 32'(TIMEOUT + 10));
    rst_n = 1'b0;
    #1;
    chk("hang_rst_dev_ce", 32'(dev_ce), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_dout = 32'h0;
`endif

    // Reset in cycle 2 of a wait-stated access
    @(negedge clk);
    dce   = 1'b1;
    daddr = 32'hBFD2_0040;
    we    = 4'h0;
    @(negedge clk);
    dce = 1'b0;
    chk("pre_rst_dev_ce", 32'(dev_ce), 32'h4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dev_ce", 32'(dev_ce), 32'h0);
    chk("mid_rst_dev_addr", dev_addr, 32'h0);
    chk("mid_rst_dout", dout, 32'h0);
    chk("mid_rst_dready", 32'(dready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_dout = 32'h0;
    do_access(32'h0000_0300, 4'h0, 32'h0, 0, 1, 32'h55AA_33CC, -1, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'h0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
